// File: rtl/seq_adder_ctrl_if.sv
// Bundles the operand, control and result signals shared by the HPS PIOs
// and the sliced adder sequencer.
interface seq_adder_ctrl_if #(
    parameter int DATA_W = 64
);
    logic [1:0]        ctrl_in;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] sum;
    logic              carry_out;
    logic              overflow;
    logic              busy;
    logic              done;

    // HPS side: drives control and operands, observes result and status
    modport master (
        output ctrl_in,
        output op_a,
        output op_b,
        input  sum,
        input  carry_out,
        input  overflow,
        input  busy,
        input  done
    );

    // Sequencer side: consumes control and operands, produces result and status
    modport slave (
        input  ctrl_in,
        input  op_a,
        input  op_b,
        output sum,
        output carry_out,
        output overflow,
        output busy,
        output done
    );
endinterface

// File: rtl/seq_adder_ctrl.sv
// Sliced 64-bit adder sequencer. Captures operands on a start edge, adds
// SLICE_W bits per cycle through a registered carry, and publishes the sum,
// unsigned carry and signed overflow when the last slice completes.
// DATA_W must be a multiple of SLICE_W.
module seq_adder_ctrl #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    seq_adder_ctrl_if.slave     bus
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int K_W        = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_startPrev;
    logic [DATA_W-1:0]   r_aReg;
    logic [DATA_W-1:0]   r_bReg;
    logic [DATA_W-1:0]   r_tmp;
    logic                r_carry;
    logic [K_W-1:0]      r_k;
    logic [DATA_W-1:0]   r_sum;
    logic                r_carryOut;
    logic                r_overflow;

    logic                w_startEdge;
    logic                w_clear;
    logic                w_lastSlice;
    int                  w_sliceBase;
    logic [SLICE_W-1:0]  w_aSlice;
    logic [SLICE_W-1:0]  w_bSlice;
    logic [SLICE_W:0]    w_sliceSum;
    logic [DATA_W-1:0]   w_merged;
    logic                w_mergedOverflow;

    assign w_startEdge = bus.ctrl_in[0] & ~r_startPrev;
    assign w_clear     = bus.ctrl_in[1];
    assign w_lastSlice = (r_k == K_W'(NUM_SLICES - 1));

    // Slice datapath: select the current operand slices, add them with the
    // stored carry, and build the full result with the final slice folded in.
    // The top slice of r_tmp is never written (it is zeroed in LOAD), so the
    // final slice can simply be OR-ed into place.
    always_comb begin
        w_sliceBase      = int'(r_k) * SLICE_W;
        w_aSlice         = r_aReg[w_sliceBase +: SLICE_W];
        w_bSlice         = r_bReg[w_sliceBase +: SLICE_W];
        w_sliceSum       = {1'b0, w_aSlice} + {1'b0, w_bSlice}
                           + {{SLICE_W{1'b0}}, r_carry};
        w_merged         = r_tmp
                           | (DATA_W'(w_sliceSum[SLICE_W-1:0]) << (DATA_W - SLICE_W));
        w_mergedOverflow = (r_aReg[DATA_W-1] == r_bReg[DATA_W-1])
                           & (w_merged[DATA_W-1] != r_aReg[DATA_W-1]);
    end

    // Control FSM and all sequential state: start edge tracking, operand
    // capture, per-slice accumulation and result publication. Clear wins over
    // everything else and drops any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_startPrev <= 1'b1;
            r_aReg      <= '0;
            r_bReg      <= '0;
            r_tmp       <= '0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_sum       <= '0;
            r_carryOut  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_startPrev <= bus.ctrl_in[0];
            if (w_clear) begin
                r_state    <= IDLE;
                r_carry    <= 1'b0;
                r_k        <= '0;
                r_sum      <= '0;
                r_carryOut <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_startEdge) begin
                            r_state <= LOAD;
                        end
                    end
                    LOAD: begin
                        r_aReg  <= bus.op_a;
                        r_bReg  <= bus.op_b;
                        r_tmp   <= '0;
                        r_carry <= 1'b0;
                        r_k     <= '0;
                        r_state <= ADD;
                    end
                    ADD: begin
                        r_carry <= w_sliceSum[SLICE_W];
                        r_k     <= r_k + K_W'(1);
                        if (w_lastSlice) begin
                            r_sum      <= w_merged;
                            r_carryOut <= w_sliceSum[SLICE_W];
                            r_overflow <= w_mergedOverflow;
                            r_state    <= DONE;
                        end else begin
                            r_tmp[w_sliceBase +: SLICE_W] <= w_sliceSum[SLICE_W-1:0];
                        end
                    end
                    DONE: begin
                        if (!bus.ctrl_in[0]) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carryOut;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = (r_state == LOAD) | (r_state == ADD);
    assign bus.done      = (r_state == DONE);

endmodule
